snoop_bus_initiator: RTL
========================

SNOOP_BUS_INITIATOR -- requirements
Module: snoop_bus_initiator

Interface
REQ-001 Parameter INDEXBITS, 8, address index width.
REQ-002 Parameter TAGBITS, 6, address tag width.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum cycles in RD state waiting for read data (range 2..255).
REQ-004 clock  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  local cache requests a bus transaction.
REQ-007 req_type  in  1  0 = BusRd, 1 = BusUpd.
REQ-008 req_addr  in  INDEXBITS+TAGBITS+2  {INDEX, TAG, BYTESELECT}.
REQ-009 req_data  in  32  update data (BusUpd only).
REQ-010 req_ready  out  1  request accepted when req_valid && req_ready at rising edge.
REQ-011 bus_req / bus_gnt  out / in  1 / 1  arbitration request and grant.
REQ-012 BusRd, BusUpd  out  1 each  snoop bus command strobes.
REQ-013 address  out  INDEXBITS+TAGBITS+2  snoop bus address; Data  out  32  snoop bus data.
REQ-014 Shared  in  1  wired-OR shared response from other caches.
REQ-015 rd_valid  in  1, rd_data  in  32  read-data return from memory/owner.
REQ-016 resp_valid  out  1, resp_data  out  32, resp_shared  out  1, resp_error  out  1  completion report.

Function
REQ-017 FSM states IDLE, ARB, RD, UPD, DONE; encoding is free.
REQ-018 IDLE: req_ready = 1 only in IDLE; on accept, capture type, address and data into holding registers and go to ARB.
REQ-019 ARB: bus_req = 1; on rising edge with bus_gnt = 1, go to RD (type 0) or UPD (type 1); otherwise stay in ARB indefinitely.
REQ-020 bus_req stays 1 from ARB through the last RD/UPD cycle; bus_req = 0 in DONE and IDLE; bus_gnt is ignored outside ARB.
REQ-021 UPD: exactly one cycle with BusUpd = 1 and address/Data driven from holding registers; Shared sampled at the closing edge into resp_shared; go to DONE.
REQ-022 RD: BusRd = 1 and address driven every cycle; Data = 0; resp_shared is the sticky OR of Shared over all RD cycles, cleared on entry to RD.
REQ-023 RD exit on rd_valid = 1: capture rd_data into resp_data and go to DONE; rd_valid is ignored outside RD.
REQ-024 RD timeout: 8-bit cycle counter cleared on RD entry; if TIMEOUT_CYCLES cycles pass without rd_valid, go to DONE with resp_error = 1 and resp_data = 0.
REQ-025 rd_valid on the same edge as the final timeout cycle takes priority: normal completion, no error.
REQ-026 DONE: resp_valid = 1 for exactly one cycle, with resp_data, resp_shared and resp_error stable during that cycle; go to IDLE.
REQ-027 Outside DONE: resp_valid = 0; resp_data, resp_shared and resp_error hold their last values.
REQ-028 BusRd and BusUpd are never 1 together; address and Data are 0 when neither strobe is active.
REQ-029 Latency with bus_gnt already high: for BusUpd, resp_valid is 3 cycles after accept; for BusRd, it is 3+k cycles after accept, where k is the number of RD cycles before rd_valid.
REQ-030 req_valid in any state other than IDLE is not accepted and not queued.

Reset
REQ-031 reset = 1 asynchronously forces IDLE and clears the holding registers, counter and all outputs to 0, except req_ready = 1.
REQ-032 Reset mid-transaction (ARB, RD or UPD) drops bus_req/BusRd/BusUpd immediately, produces no resp_valid, and discards the request.

Verification
REQ-033 BusUpd: addr {8'd5, 6'd1, 2'd0}, data 32'habcdef12, gnt high, Shared = 1 -> exactly one BusUpd cycle with that address/data; resp_valid 3 cycles after accept with resp_shared = 1, resp_error = 0.
REQ-034 BusRd: gnt high, rd_valid on 3rd RD cycle with rd_data 32'h12345678, Shared pulsed only in RD cycle 1 -> resp_data 32'h12345678, resp_shared = 1, BusRd high exactly 3 cycles.
REQ-035 Grant delay: bus_gnt held low 5 cycles then high -> bus_req high 5 cycles in ARB with no strobe, then normal BusUpd; req_valid pulses while busy are ignored (req_ready = 0).
REQ-036 Timeout: BusRd with rd_valid never asserted, TIMEOUT_CYCLES = 16 -> BusRd high exactly 16 cycles, then resp_valid with resp_error = 1, resp_data = 0; second case with rd_valid on cycle 16 -> no error.
REQ-037 Reset mid-RD: reset asserted between edges in RD cycle 2 -> BusRd and bus_req drop without waiting for a clock edge, no resp_valid, req_ready = 1; a following BusUpd completes normally.

Source files
------------

// File: rtl/snoop_bus_initiator_if.sv
// Snoop bus initiator interface: local cache request channel, snoop bus
// arbitration and command/address/data, read-data return and completion report.
interface snoop_bus_initiator_if #(
  parameter int unsigned INDEXBITS = 8,
  parameter int unsigned TAGBITS   = 6
) ();
  localparam int unsigned AW = INDEXBITS + TAGBITS + 2;

  // Request channel from the local cache
  logic          req_valid;
  logic          req_type;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic          req_ready;

  // Arbitration and snoop bus
  logic          bus_req;
  logic          bus_gnt;
  logic          BusRd;
  logic          BusUpd;
  logic [AW-1:0] address;
  logic [31:0]   Data;
  logic          Shared;

  // Read-data return
  logic          rd_valid;
  logic [31:0]   rd_data;

  // Completion report
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_shared;
  logic          resp_error;

  // Initiator side
  modport master (
    input  req_valid, req_type, req_addr, req_data,
    input  bus_gnt, Shared, rd_valid, rd_data,
    output req_ready, bus_req, BusRd, BusUpd, address, Data,
    output resp_valid, resp_data, resp_shared, resp_error
  );

  // Environment side (cache, arbiter, other snoopers, memory)
  modport slave (
    output req_valid, req_type, req_addr, req_data,
    output bus_gnt, Shared, rd_valid, rd_data,
    input  req_ready, bus_req, BusRd, BusUpd, address, Data,
    input  resp_valid, resp_data, resp_shared, resp_error
  );
endinterface

// File: rtl/snoop_bus_initiator.sv
// Snoop bus initiator: accepts one BusRd/BusUpd request from the local cache,
// arbitrates for the snoop bus, runs the command and reports completion.
module snoop_bus_initiator #(
  parameter int unsigned INDEXBITS      = 8,
  parameter int unsigned TAGBITS        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  snoop_bus_initiator_if.master bus
);
  localparam int unsigned AW = INDEXBITS + TAGBITS + 2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RD,
    S_UPD,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          hold_type;
  logic [AW-1:0] hold_addr;
  logic [31:0]   hold_data;
  logic [7:0]    cnt;
  logic          shared_acc;
  logic [31:0]   resp_data_r;
  logic          resp_shared_r;
  logic          resp_error_r;
  logic          rd_timeout;

  assign rd_timeout = (cnt == CNT_LAST);

  // Next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.req_valid) state_nx = S_ARB;
      S_ARB:  if (bus.bus_gnt) state_nx = hold_type ? S_UPD : S_RD;
      S_RD:   if (bus.rd_valid || rd_timeout) state_nx = S_DONE;
      S_UPD:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus-facing outputs decoded from state so a reset drops them immediately
  always_comb begin
    bus.req_ready   = (state == S_IDLE);
    bus.bus_req     = (state == S_ARB) || (state == S_RD) || (state == S_UPD);
    bus.BusRd       = (state == S_RD);
    bus.BusUpd      = (state == S_UPD);
    bus.address     = '0;
    bus.Data        = '0;
    if ((state == S_RD) || (state == S_UPD)) bus.address = hold_addr;
    if (state == S_UPD) bus.Data = hold_data;
    bus.resp_valid  = (state == S_DONE);
    bus.resp_data   = resp_data_r;
    bus.resp_shared = resp_shared_r;
    bus.resp_error  = resp_error_r;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Holding registers, RD timeout counter, Shared accumulation, response capture.
  // The sticky Shared OR is kept internally and only copied to resp_shared on
  // the edge into DONE, so the visible report holds its old value until then.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_type     <= 1'b0;
      hold_addr     <= '0;
      hold_data     <= '0;
      cnt           <= '0;
      shared_acc    <= 1'b0;
      resp_data_r   <= '0;
      resp_shared_r <= 1'b0;
      resp_error_r  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            hold_type <= bus.req_type;
            hold_addr <= bus.req_addr;
            hold_data <= bus.req_data;
          end
        end
        S_ARB: begin
          if (bus.bus_gnt) begin
            cnt        <= '0;
            shared_acc <= 1'b0;
          end
        end
        S_RD: begin
          cnt        <= cnt + 8'd1;
          shared_acc <= shared_acc | bus.Shared;
          if (bus.rd_valid) begin
            resp_data_r   <= bus.rd_data;
            resp_error_r  <= 1'b0;
            resp_shared_r <= shared_acc | bus.Shared;
          end else if (rd_timeout) begin
            resp_data_r   <= '0;
            resp_error_r  <= 1'b1;
            resp_shared_r <= shared_acc | bus.Shared;
          end
        end
        S_UPD: begin
          resp_shared_r <= bus.Shared;
          resp_error_r  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
